mux2_stream_arb: RTL and testbench
==================================

// Module: mux2_stream_arb
//
// PURPOSE
// - Merges two val/rdy message streams into one output stream, one message per cycle.
// - Round-robin arbitration between in0 and in1 generates the 2:1 mux select.
// - A single-entry output register holds the winner and records which input it came from.
// - Sits in front of downstream consumers that need one serialized stream and the source tag.
//
// PARAMETERS
// - NBITS   default 8   width of in0_msg, in1_msg and out_msg
//
// PORTS
// - clk      input   1      clock; all state updates on the rising edge
// - reset_n  input   1      asynchronous active-low reset
// - in0_val  input   1      in0 message valid
// - in0_rdy  output  1      in0 accepted this cycle when in0_val && in0_rdy
// - in0_msg  input   NBITS  in0 message
// - in1_val  input   1      in1 message valid
// - in1_rdy  output  1      in1 accepted this cycle when in1_val && in1_rdy
// - in1_msg  input   NBITS  in1 message
// - out_val  output  1      output register holds a message
// - out_rdy  input   1      downstream takes the message when out_val && out_rdy
// - out_msg  output  NBITS  buffered message
// - out_src  output  1      source of the buffered message: 0 = in0, 1 = in1
//
// BEHAVIOUR
// - Reset (reset_n low, async): out_val=0, out_msg=0, out_src=0, priority pointer=in0.
//   Any buffered message is discarded.
// - Transfer rule: a transfer happens on a rising edge where val && rdy on that interface.
// - can_accept = !out_val || out_rdy. When full and drained, a new message loads in the same cycle.
// - Grant (combinational, from in*_val and the priority pointer):
//   - only in0_val -> grant in0
//   - only in1_val -> grant in1
//   - both valid   -> grant the input named by the priority pointer
// - in0_rdy = can_accept && grant==in0; in1_rdy = can_accept && grant==in1.
//   - Never both 1.
//   - rdy may depend on val and out_rdy.
//   - out_val never depends on any rdy.
// - On an accept:
//   - out_msg = winner msg, out_src = winner, out_val = 1
//   - priority pointer = the other input (also when the winner was the only requester).
// - Output drain without a new accept: out_val = 0; out_msg and out_src hold their values.
// - Stall (out_val && !out_rdy): out_msg and out_src stay stable; both in*_rdy = 0; pointer holds.
// - No input valid: pointer holds.
// - Latency: one cycle from input accept to out_val.
// - Throughput: one message per cycle while out_rdy = 1.
// - Back-to-back both-valid with out_rdy = 1: grants alternate 0,1,0,1...
//
// STRUCTURE
// - Package mux2_stream_arb_pkg:
//   - localparams SRC_IN0 = 1'b0 and SRC_IN1 = 1'b1
//   - typedef src_t (1-bit) for out_src and the priority pointer
// - Sub-module rr_arb2: two-requester round-robin arbiter.
//   - Holds the priority flop (async active-low reset).
//   - Outputs grant; takes an advance input that is asserted on accept.
// - Top level holds:
//   - the NBITS-wide 2:1 select on the messages, driven by the grant
//   - the output register with its val/src flops
//   - the rdy logic
//
// TESTING
// - Reset: hold reset_n=0 with both inputs valid
//   -> out_val=0, in0_rdy=in1_rdy=0 until reset_n=1.
//   - First both-valid cycle after release grants in0.
// - Single source: in0 sends 0x11,0x22,0x33 with out_rdy=1
//   -> out_msg 0x11,0x22,0x33 on consecutive cycles, each one cycle later; out_src=0 throughout.
// - Fairness: in0 fixed 0xA0 and in1 fixed 0xB1 both valid, out_rdy=1, for 6 cycles
//   -> out_src 0,1,0,1,0,1 with matching out_msg.
// - Backpressure: fill with 0x5C from in1, then out_rdy=0 for 3 cycles
//   -> out_msg=0x5C, out_src=1 stable; in0_rdy=in1_rdy=0.
//   - When out_rdy returns to 1, the next message is accepted in that same cycle.
// - Reset mid-operation: assert reset_n=0 while out_val=1 and stalled
//   -> out_val=0 immediately, without waiting for a clock edge; the message is lost.
//   - Priority returns to in0.

Source files
------------

// File: rtl/mux2_stream_arb_pkg.sv
// Shared types and constants for the two-input round-robin stream merger.
package mux2_stream_arb_pkg;

  typedef logic src_t;

  localparam src_t SRC_IN0 = 1'b0;
  localparam src_t SRC_IN1 = 1'b1;

  function automatic src_t other_src(input src_t s);
    return (s == SRC_IN0) ? SRC_IN1 : SRC_IN0;
  endfunction

endpackage

// File: rtl/mux2_stream_arb_rr_arb2.sv
// Two-requester round-robin arbiter: a single priority flop that moves to the
// opposite input whenever the current grant is consumed.
module rr_arb2
  import mux2_stream_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output src_t grant
);

  src_t prio;

  // With no requester the grant simply follows the pointer; nobody can accept then.
  always_comb begin
    grant = prio;
    if (req0 && !req1) begin
      grant = SRC_IN0;
    end else if (req1 && !req0) begin
      grant = SRC_IN1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= SRC_IN0;
    end else if (advance) begin
      prio <= other_src(grant);
    end
  end

endmodule

// File: rtl/mux2_stream_arb.sv
// Merges two val/rdy streams into one single-entry output register, tagging
// each buffered message with the input it came from.
module mux2_stream_arb
  import mux2_stream_arb_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in0_val,
  output logic             in0_rdy,
  input  logic [NBITS-1:0] in0_msg,
  input  logic             in1_val,
  output logic             in1_rdy,
  input  logic [NBITS-1:0] in1_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_msg,
  output src_t             out_src
);

  src_t             grant;
  logic             can_accept;
  logic             accept;
  logic [NBITS-1:0] sel_msg;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (in0_val),
    .req1    (in1_val),
    .advance (accept),
    .grant   (grant)
  );

  // Readiness is held low while reset is asserted so nothing is offered mid-reset.
  assign can_accept = !out_val || out_rdy;
  assign in0_rdy    = reset_n && can_accept && (grant == SRC_IN0);
  assign in1_rdy    = reset_n && can_accept && (grant == SRC_IN1);
  assign accept     = (in0_val && in0_rdy) || (in1_val && in1_rdy);
  assign sel_msg    = (grant == SRC_IN1) ? in1_msg : in0_msg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_val <= 1'b0;
      out_msg <= '0;
      out_src <= SRC_IN0;
    end else if (accept) begin
      out_val <= 1'b1;
      out_msg <= sel_msg;
      out_src <= grant;
    end else if (out_rdy) begin
      out_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_stream_arb.sv
// Scoreboard bench for mux2_stream_arb: expected {src,msg} pairs are queued as
// stimulus is driven and popped when the output register presents them.
module tb_mux2_stream_arb;

  logic       clk;
  logic       reset_n;
  logic       in0_val, in1_val, in0_rdy, in1_rdy;
  logic [7:0] in0_msg, in1_msg, out_msg;
  logic       out_val, out_rdy;
  logic       out_src;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb_q[$];
  logic [8:0] exp_item;

  mux2_stream_arb #(.NBITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in0_val (in0_val),
    .in0_rdy (in0_rdy),
    .in0_msg (in0_msg),
    .in1_val (in1_val),
    .in1_rdy (in1_rdy),
    .in1_msg (in1_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in0_val = 1'b0;
    in1_val = 1'b0;
    out_rdy = 1'b1;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in0_val = 1'b1; in0_msg = 8'h01;
    in1_val = 1'b1; in1_msg = 8'h02;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_val, in0_rdy, in1_rdy} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_hold: got val/rdy0/rdy1=%b required 000", {out_val, in0_rdy, in1_rdy});
      end
      tick();
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if ({in0_rdy, in1_rdy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: got rdy0/rdy1=%b required 10", {in0_rdy, in1_rdy});
    end
    sb_q.push_back({1'b0, 8'h01});
    tick();
    exp_item = sb_q.pop_front();
    checks++;
    if ({out_val, out_src, out_msg} !== {1'b1, exp_item}) begin
      errors++;
      $display("[TB] FAIL reset_first_out: got val/src/msg=%b/%b/%h required 1/%b/%h",
               out_val, out_src, out_msg, exp_item[8], exp_item[7:0]);
    end
    in0_val = 1'b0;
    in1_val = 1'b0;
    tick();
  endtask

  task automatic test_single_source();
    logic [7:0] msgs [3];
    msgs = '{8'h11, 8'h22, 8'h33};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in0_val = 1'b1;
      in0_msg = msgs[i];
      @(negedge clk);
      checks++;
      if (in0_rdy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL single_rdy%0d: got %b required 1", i, in0_rdy);
      end
      sb_q.push_back({1'b0, msgs[i]});
      tick();
      exp_item = sb_q.pop_front();
      checks++;
      if ({out_val, out_src, out_msg} !== {1'b1, exp_item}) begin
        errors++;
        $display("[TB] FAIL single_out%0d: got val/src/msg=%b/%b/%h required 1/%b/%h",
                 i, out_val, out_src, out_msg, exp_item[8], exp_item[7:0]);
      end
    end
    in0_val = 1'b0;
    tick();
    checks++;
    if (out_val !== 1'b0 || out_msg !== 8'h33) begin
      errors++;
      $display("[TB] FAIL single_drain: got val/msg=%b/%h required 0/33", out_val, out_msg);
    end
  endtask

  task automatic test_fairness();
    logic exp_src;
    do_reset();
    in0_val = 1'b1; in0_msg = 8'hA0;
    in1_val = 1'b1; in1_msg = 8'hB1;
    for (int i = 0; i < 6; i++) begin
      exp_src = (i % 2 == 1);
      @(negedge clk);
      checks++;
      if ({in0_rdy, in1_rdy} !== {!exp_src, exp_src}) begin
        errors++;
        $display("[TB] FAIL fair_rdy%0d: got rdy0/rdy1=%b%b required %b%b", i, in0_rdy, in1_rdy, !exp_src, exp_src);
      end
      sb_q.push_back({exp_src, exp_src ? 8'hB1 : 8'hA0});
      tick();
      exp_item = sb_q.pop_front();
      checks++;
      if ({out_val, out_src, out_msg} !== {1'b1, exp_item}) begin
        errors++;
        $display("[TB] FAIL fair_out%0d: got val/src/msg=%b/%b/%h required 1/%b/%h",
                 i, out_val, out_src, out_msg, exp_item[8], exp_item[7:0]);
      end
    end
    in0_val = 1'b0;
    in1_val = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    in1_val = 1'b1; in1_msg = 8'h5C;
    @(negedge clk);
    sb_q.push_back({1'b1, 8'h5C});
    tick();
    exp_item = sb_q.pop_front();
    checks++;
    if ({out_val, out_src, out_msg} !== {1'b1, exp_item}) begin
      errors++;
      $display("[TB] FAIL bp_fill: got val/src/msg=%b/%b/%h required 1/1/5c", out_val, out_src, out_msg);
    end
    out_rdy = 1'b0;
    in1_val = 1'b0;
    in0_val = 1'b1; in0_msg = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_val, out_src, out_msg, in0_rdy, in1_rdy} !== {1'b1, 1'b1, 8'h5C, 2'b00}) begin
        errors++;
        $display("[TB] FAIL bp_stall%0d: got val/src/msg/rdy0/rdy1=%b/%b/%h/%b/%b required 1/1/5c/0/0",
                 i, out_val, out_src, out_msg, in0_rdy, in1_rdy);
      end
      tick();
    end
    out_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (in0_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_rdy: got %b required 1", in0_rdy);
    end
    sb_q.push_back({1'b0, 8'h77});
    tick();
    exp_item = sb_q.pop_front();
    checks++;
    if ({out_val, out_src, out_msg} !== {1'b1, exp_item}) begin
      errors++;
      $display("[TB] FAIL bp_release_out: got val/src/msg=%b/%b/%h required 1/0/77", out_val, out_src, out_msg);
    end
    in0_val = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in0_val = 1'b1; in0_msg = 8'h3E;
    @(negedge clk);
    sb_q.push_back({1'b0, 8'h3E});
    tick();
    exp_item = sb_q.pop_front();
    checks++;
    if ({out_val, out_src, out_msg} !== {1'b1, exp_item}) begin
      errors++;
      $display("[TB] FAIL mid_fill: got val/src/msg=%b/%b/%h required 1/0/3e", out_val, out_src, out_msg);
    end
    out_rdy = 1'b0;
    in0_val = 1'b0;
    tick();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_val, out_src, out_msg} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL mid_async_clear: got val/src/msg=%b/%b/%h required 0/0/00", out_val, out_src, out_msg);
    end
    in0_val = 1'b1; in0_msg = 8'hA0;
    in1_val = 1'b1; in1_msg = 8'hB1;
    out_rdy = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if ({in0_rdy, in1_rdy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL mid_prio_in0: got rdy0/rdy1=%b%b required 10", in0_rdy, in1_rdy);
    end
    sb_q.push_back({1'b0, 8'hA0});
    tick();
    exp_item = sb_q.pop_front();
    checks++;
    if ({out_val, out_src, out_msg} !== {1'b1, exp_item}) begin
      errors++;
      $display("[TB] FAIL mid_after_out: got val/src/msg=%b/%b/%h required 1/0/a0", out_val, out_src, out_msg);
    end
    in0_val = 1'b0;
    in1_val = 1'b0;
    tick();
  endtask

  task automatic test_sole_advance();
    logic [7:0] exp_msg [3];
    logic       exp_src [3];
    exp_msg = '{8'h44, 8'h66, 8'h55};
    exp_src = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in0_val = 1'b1;
      in1_val = (i != 0);
      in0_msg = (i == 0) ? 8'h44 : 8'h55;
      in1_msg = 8'h66;
      @(negedge clk);
      checks++;
      if ({in0_rdy, in1_rdy} !== {!exp_src[i], exp_src[i]}) begin
        errors++;
        $display("[TB] FAIL sole_rdy%0d: got rdy0/rdy1=%b%b required %b%b", i, in0_rdy, in1_rdy, !exp_src[i], exp_src[i]);
      end
      sb_q.push_back({exp_src[i], exp_msg[i]});
      tick();
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sole_empty%0d: got empty scoreboard required one entry", i);
      end else begin
        exp_item = sb_q.pop_front();
        checks++;
        if ({out_val, out_src, out_msg} !== {1'b1, exp_item}) begin
          errors++;
          $display("[TB] FAIL sole_out%0d: got val/src/msg=%b/%b/%h required 1/%b/%h",
                   i, out_val, out_src, out_msg, exp_item[8], exp_item[7:0]);
        end
      end
      if (i == 1) begin
        in0_val = 1'b0;
        in1_val = 1'b0;
        repeat (3) tick();
      end
    end
    in0_val = 1'b0;
    in1_val = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    in0_val = 1'b0; in1_val = 1'b0;
    in0_msg = '0;   in1_msg = '0;
    out_rdy = 1'b1;
    tick();
    test_reset();
    test_single_source();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_sole_advance();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
